// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch control FSM: boot delay, memory-latency wait, stall, branch redirect, halt.
// Optional perf counters (o_fetch_cnt / o_stall_cnt) are enabled with macro FETCH_PERF_CNT_EN.
module if_fetch_ctrl #(
  parameter int MEM_LAT     = 1,
  parameter int BOOT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_hazard_stall,
  input  logic        i_br_taken,
  input  logic        i_halt,
  output logic        o_pc_en,
  output logic        o_pc_sel,
  output logic        o_if_valid,
  output logic        o_flush_ifid,
  output logic        o_flush_idex,
  output logic [2:0]  o_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT     = 3'd2,
    S_REDIRECT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam logic [3:0] BOOT_LD   = 4'(BOOT_CYCLES);
  localparam logic [3:0] LAT_LD    = 4'(MEM_LAT - 1);
  // Where a new fetch starts: straight to FETCH for single-cycle memory, else wait it out.
  localparam state_t     ISSUE_NXT = (MEM_LAT == 1) ? S_FETCH : S_WAIT;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pc_en, if_valid, redir, stall_hit;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_BOOT;
      cnt_q   <= BOOT_LD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_en     = 1'b0;
    if_valid  = 1'b0;
    redir     = 1'b0;
    stall_hit = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ISSUE_NXT;
          cnt_d   = LAT_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FETCH: begin
        if (i_halt)               state_d = S_HALT;
        else if (i_br_taken)      redir = 1'b1;
        else if (i_hazard_stall)  stall_hit = 1'b1;
        else begin
          pc_en    = 1'b1;
          if_valid = 1'b1;
          state_d  = ISSUE_NXT;
          cnt_d    = LAT_LD;
        end
      end
      S_WAIT: begin
        if (i_halt)              state_d = S_HALT;
        else if (i_br_taken)     redir = 1'b1;
        else if (cnt_q <= 4'd1)  state_d = S_FETCH;
        else                     cnt_d = cnt_q - 4'd1;
      end
      S_REDIRECT: begin
        // Any fetch in flight before the redirect is dropped by restarting the latency count.
        if (i_halt)           state_d = S_HALT;
        else if (i_br_taken)  redir = 1'b1;
        else begin
          state_d = ISSUE_NXT;
          cnt_d   = LAT_LD;
        end
      end
      S_HALT: ;
      default: begin
        state_d = S_BOOT;
        cnt_d   = BOOT_LD;
      end
    endcase
    if (redir) begin
      pc_en   = 1'b1;
      state_d = S_REDIRECT;
    end
  end

  assign o_pc_en      = pc_en;
  assign o_pc_sel     = redir;
  assign o_if_valid   = if_valid;
  assign o_flush_ifid = redir;
  assign o_flush_idex = redir;
  assign o_state      = state_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_fetch_cnt <= 32'd0;
      o_stall_cnt <= 32'd0;
    end else begin
      if (if_valid)  o_fetch_cnt <= o_fetch_cnt + 32'd1;
      if (stall_hit) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
